alu_decoder_stage: RTL
======================

ALU_DECODER_STAGE -- requirements
Module: alu_decoder_stage

Interface
REQ-001 The block SHALL expose parameter XLEN, default 32, datapath width; only 32 is supported.
REQ-002 The block SHALL expose clk  input  1  sole clock, all state updates on rising edge.
REQ-003 The block SHALL expose rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL expose in_valid  input  1  upstream instruction valid.
REQ-005 The block SHALL expose in_ready  output  1  stage can accept an instruction.
REQ-006 The block SHALL expose instr  input  32  RV32I instruction word.
REQ-007 The block SHALL expose pc, rs1_data, rs2_data  input  32 each  instruction PC and register operands.
REQ-008 The block SHALL expose flush  input  1  discard all held and incoming instructions.
REQ-009 The block SHALL expose out_valid  output  1  decoded ALU command valid.
REQ-010 The block SHALL expose out_ready  input  1  ALU-side consumer accepts the command.
REQ-011 The block SHALL expose alu_op  output  4, alu_x  output  32, alu_y  output  32  ALU operation code and operands.
REQ-012 The block SHALL expose br_invert  output  1 (BNE result inversion) and illegal  output  1 (unsupported opcode/funct).

Function
REQ-013 Op codes SHALL be: AND 0000, OR 0001, ADD 0010, EQ 0011, SLL 0100, SRL 0101, SRA 0111, XOR 1000, NOR 1001, SUB 1010, GE 1100, GEU 1101, SLT 1110, SLTU 1111.
REQ-014 OP (0110011): funct3 000 ADD/SUB by instr[30], 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA by instr[30], 110 OR, 111 AND; x=rs1_data, y=rs2_data.
REQ-015 OP-IMM (0010011): same map without SUB, SRAI by instr[30]; x=rs1_data, y=sign-extended I-immediate (shifts: y={27'b0,instr[24:20]}).
REQ-016 LUI: ADD, x=0, y={instr[31:12],12'b0}; AUIPC: ADD, x=pc, y=U-immediate; JAL/JALR: ADD, x=pc, y=4.
REQ-017 LOAD: ADD, x=rs1, y=I-imm; STORE: ADD, x=rs1, y=sign-extended S-imm.
REQ-018 BRANCH: BEQ EQ, BNE EQ with br_invert=1, BLT SLT, BGE GE, BLTU SLTU, BGEU GEU; x=rs1, y=rs2; br_invert=0 for all others.
REQ-019 Any other opcode or reserved funct3/funct7 SHALL produce illegal=1, alu_op=ADD, alu_x=alu_y=0, and still flow through the handshake.
REQ-020 An instruction SHALL be accepted when in_valid && in_ready and appear on outputs exactly one cycle later with out_valid=1.
REQ-021 Output SHALL hold stable while out_valid && !out_ready; a transfer occurs on out_valid && out_ready.
REQ-022 Without skid buffer, in_ready SHALL equal !out_valid || out_ready (combinational), giving full throughput.
REQ-023 flush SHALL clear out_valid (and skid entry) next cycle; a same-cycle accepted input SHALL be dropped; flush overrides in_valid.
REQ-024 Simultaneous transfer-out and accept-in SHALL replace the output register with no bubble.

Reset
REQ-025 On rst_n low, out_valid=0, alu_op=ADD, alu_x=alu_y=0, br_invert=0, illegal=0, skid entry empty, immediately and independent of clk.
REQ-026 Reset asserted mid-handshake SHALL discard all held instructions; no output transfer occurs until a new acceptance.

Configuration
REQ-027 Macro ALU_DECODER_SKID_EN defined: a one-entry skid buffer is compiled in and in_ready is a register output equal to !skid_valid; an input accepted while output stalls goes to skid, then moves to output on the next transfer.
REQ-028 Macro undefined: no skid storage; in_ready per REQ-022; decode results identical in both builds.

Structure
REQ-029 Op-code constants, RV32I opcode constants and a decoded-command struct (op, x, y, br_invert, illegal) SHALL live in the shared core package.
REQ-030 Combinational decode SHALL be one sub-module alu_op_decode; alu_decoder_stage holds handshake, output and skid registers.

Verification
REQ-031 ADD x1,x2,x3 with rs1=5, rs2=7, out_ready=1 -> next cycle out_valid=1, alu_op=0010, x=5, y=7.
REQ-032 SRAI (instr[30]=1, shamt 4), rs1=32'hF000_0000 -> alu_op=0111, y=4; ADDI imm=-1 -> y=32'hFFFF_FFFF.
REQ-033 BNE rs1=3, rs2=3 -> alu_op=0011, br_invert=1; opcode 7'b1111111 -> illegal=1, alu_op=0010, x=y=0.
REQ-034 out_ready=0 for 3 cycles with in_valid=1 -> outputs stable; no-skid build in_ready=0; skid build accepts one more then in_ready=0; order preserved on release.
REQ-035 flush in same cycle as accepted input -> out_valid=0 next cycle, dropped input never appears.
REQ-036 rst_n low while out_valid=1 -> out_valid=0 without clock edge; all outputs at reset values.

Source files
------------

// File: rtl/alu_decoder_stage_pkg.sv
// Shared core package for the ALU decoder stage: ALU op codes, RV32I opcodes,
// the decoded-command struct and the funct3-to-op mapping shared by OP and OP-IMM.
package alu_decoder_stage_pkg;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_EQ   = 4'b0011,
        ALU_SLL  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_SRA  = 4'b0111,
        ALU_XOR  = 4'b1000,
        ALU_NOR  = 4'b1001,
        ALU_SUB  = 4'b1010,
        ALU_GE   = 4'b1100,
        ALU_GEU  = 4'b1101,
        ALU_SLT  = 4'b1110,
        ALU_SLTU = 4'b1111
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef struct packed {
        alu_op_e     op;
        logic [31:0] x;
        logic [31:0] y;
        logic        br_invert;
        logic        illegal;
    } alu_cmd_t;

    localparam alu_cmd_t CMD_RESET = '{
        op:        ALU_ADD,
        x:         32'h0,
        y:         32'h0,
        br_invert: 1'b0,
        illegal:   1'b0
    };

    // alt selects SUB/SRA; callers pass 0 where the alternate form does not exist.
    function automatic alu_op_e funct3_op(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'b000:  funct3_op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  funct3_op = ALU_SLL;
            3'b010:  funct3_op = ALU_SLT;
            3'b011:  funct3_op = ALU_SLTU;
            3'b100:  funct3_op = ALU_XOR;
            3'b101:  funct3_op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  funct3_op = ALU_OR;
            default: funct3_op = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder_stage_decode.sv
// Combinational RV32I decode into an ALU command (op, operands, branch inversion,
// illegal flag). Illegal encodings collapse to ADD with zero operands.
module alu_op_decode
    import alu_decoder_stage_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output alu_cmd_t    cmd
);

    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_u;
    logic [31:0] shamt;
    logic        illegal_op;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_u  = {instr[31:12], 12'b0};
    assign shamt  = {27'b0, instr[24:20]};

    always_comb begin
        // NOTE: every output gets a default first so no path through the case can infer a latch.
        cmd        = CMD_RESET;
        illegal_op = 1'b0;
        case (opcode)
            OPC_OP: begin
                cmd.x      = rs1_data;
                cmd.y      = rs2_data;
                cmd.op     = funct3_op(funct3, instr[30]);
                illegal_op = !((funct7 == 7'b0000000) ||
                               (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)));
            end
            OPC_OP_IMM: begin
                cmd.x  = rs1_data;
                cmd.y  = imm_i;
                cmd.op = funct3_op(funct3, (funct3 == 3'b101) && instr[30]);
                if (funct3 == 3'b001) begin
                    cmd.y      = shamt;
                    illegal_op = (funct7 != 7'b0000000);
                end else if (funct3 == 3'b101) begin
                    cmd.y      = shamt;
                    illegal_op = !(funct7 == 7'b0000000 || funct7 == 7'b0100000);
                end
            end
            OPC_LUI: begin
                cmd.y = imm_u;
            end
            OPC_AUIPC: begin
                cmd.x = pc;
                cmd.y = imm_u;
            end
            OPC_JAL: begin
                cmd.x = pc;
                cmd.y = 32'd4;
            end
            OPC_JALR: begin
                cmd.x      = pc;
                cmd.y      = 32'd4;
                illegal_op = (funct3 != 3'b000);
            end
            OPC_LOAD: begin
                cmd.x      = rs1_data;
                cmd.y      = imm_i;
                illegal_op = (funct3 inside {3'b011, 3'b110, 3'b111});
            end
            OPC_STORE: begin
                cmd.x      = rs1_data;
                cmd.y      = imm_s;
                illegal_op = (funct3 > 3'b010);
            end
            OPC_BRANCH: begin
                cmd.x = rs1_data;
                cmd.y = rs2_data;
                case (funct3)
                    3'b000:  cmd.op = ALU_EQ;
                    3'b001: begin
                        cmd.op        = ALU_EQ;
                        cmd.br_invert = 1'b1;
                    end
                    3'b100:  cmd.op = ALU_SLT;
                    3'b101:  cmd.op = ALU_GE;
                    3'b110:  cmd.op = ALU_SLTU;
                    3'b111:  cmd.op = ALU_GEU;
                    default: illegal_op = 1'b1;
                endcase
            end
            default: illegal_op = 1'b1;
        endcase

        if (illegal_op) begin
            cmd         = CMD_RESET;
            cmd.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/alu_decoder_stage.sv
// ALU decoder pipeline stage: valid/ready handshake around alu_op_decode with a
// registered output. Define ALU_DECODER_SKID_EN to add a one-entry skid buffer.
module alu_decoder_stage
    import alu_decoder_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      alu_op,
    output logic [XLEN-1:0] alu_x,
    output logic [XLEN-1:0] alu_y,
    output logic            br_invert,
    output logic            illegal
);

    alu_cmd_t dec_cmd;
    alu_cmd_t out_cmd_q, out_cmd_d;
    logic     out_valid_q, out_valid_d;
    logic     out_free;
    logic     accept;

    alu_op_decode u_decode (
        .instr    (instr),
        .pc       (pc),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .cmd      (dec_cmd)
    );

    assign out_free = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;

`ifdef ALU_DECODER_SKID_EN
    alu_cmd_t skid_cmd_q, skid_cmd_d;
    logic     skid_valid_q, skid_valid_d;

    assign in_ready = !skid_valid_q;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_cmd_d    = out_cmd_q;
        skid_valid_d = skid_valid_q;
        skid_cmd_d   = skid_cmd_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_free) begin
            // A held skid entry is older than anything on the input, so it drains first.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_cmd_d    = skid_cmd_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_valid_d = 1'b1;
                out_cmd_d   = dec_cmd;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_cmd_d   = dec_cmd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_valid_q <= 1'b0;
            skid_cmd_q   <= CMD_RESET;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_cmd_q   <= skid_cmd_d;
        end
    end
`else
    assign in_ready = out_free;

    always_comb begin
        out_valid_d = out_valid_q;
        out_cmd_d   = out_cmd_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            out_cmd_d   = dec_cmd;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the command payload is reset too, because its reset value is visible on the outputs.
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_cmd_q   <= CMD_RESET;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            out_valid_q <= out_valid_d;
            out_cmd_q   <= out_cmd_d;
        end
    end

    assign out_valid = out_valid_q;
    assign alu_op    = out_cmd_q.op;
    assign alu_x     = out_cmd_q.x;
    assign alu_y     = out_cmd_q.y;
    assign br_invert = out_cmd_q.br_invert;
    assign illegal   = out_cmd_q.illegal;

endmodule
